// File: rtl/i2c_target_regfile.sv
// I2C target with a 2**REG_AW byte register file: burst write and combined/burst read over SCL/SDA.
// Latency: SCL/SDA see 2-flop sync + 1 delay flop; SDA_out updates 3 clk after a raw SCL fall; host_rdata 1 clk.
// Backpressure: none; the I2C master owns the pace, and the target only ACKs or NACKs on the bus.
module i2c_target_regfile #(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned REG_AW   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCL_in,
    input  logic              SDA_in,
    output logic              SDA_out,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    input  logic [REG_AW-1:0] host_raddr,
    output logic [7:0]        host_rdata
);

    localparam int DEPTH = 2 ** REG_AW;

    typedef enum logic [3:0] {
        S_IDLE, S_DEV, S_ACK_DEV, S_REG, S_ACK_REG,
        S_WR, S_ACK_WR, S_RD, S_RD_ACK, S_IGNORE
    } state_t;

    logic scl_s1_q, scl_s2_q, scl_dly_q;
    logic sda_s1_q, sda_s2_q, sda_dly_q;

    state_t            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [REG_AW-1:0] ptr_q, ptr_d;
    logic              sda_q, sda_d;
    logic              busy_q, busy_d;
    logic              wr_en_q, wr_en_d;
    logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;

    logic [7:0] regs_q [DEPTH];
    logic [7:0] host_rdata_q;

    logic       scl_rise, scl_fall, start_det, stop_det, reg_ok;
    logic [7:0] shift_in;

    // Bring the asynchronous bus lines into clk; idle bus level is high on both lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1_q  <= 1'b1;
            scl_s2_q  <= 1'b1;
            scl_dly_q <= 1'b1;
            sda_s1_q  <= 1'b1;
            sda_s2_q  <= 1'b1;
            sda_dly_q <= 1'b1;
        end else begin
            scl_s1_q  <= SCL_in;
            scl_s2_q  <= scl_s1_q;
            scl_dly_q <= scl_s2_q;
            sda_s1_q  <= SDA_in;
            sda_s2_q  <= sda_s1_q;
            sda_dly_q <= sda_s2_q;
        end
    end

    assign scl_rise  = scl_s2_q & ~scl_dly_q;
    assign scl_fall  = ~scl_s2_q & scl_dly_q;
    // START/STOP only count while SCL has been stably high for two samples.
    assign start_det = scl_s2_q & scl_dly_q & sda_dly_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_dly_q & ~sda_dly_q & sda_s2_q;
    assign shift_in  = {shift_q[6:0], sda_s2_q};
    assign reg_ok    = ({24'd0, shift_q} < 32'(DEPTH));

    // Protocol FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            sda_q     <= 1'b1;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_q     <= sda_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next-state logic: bits are sampled on SCL rise, SDA drive only changes on SCL fall.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_d     = sda_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (stop_det) begin
            state_d = S_IDLE;
            sda_d   = 1'b1;
            busy_d  = 1'b0;
        end else if (start_det) begin
            // Pointer is kept so a repeated START continues a combined read.
            state_d   = S_DEV;
            bit_cnt_d = '0;
            sda_d     = 1'b1;
        end else begin
            case (state_q)
                S_DEV: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (shift_q[7:1] == DEV_ADDR) begin
                            state_d = S_ACK_DEV;
                            sda_d   = 1'b0;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = S_IGNORE;
                            sda_d   = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                end
                S_ACK_DEV: begin
                    if (scl_fall) begin
                        if (shift_q[0]) begin
                            // Read: MSB goes out on the same fall that ends the ACK.
                            state_d   = S_RD;
                            shift_d   = regs_q[ptr_q];
                            sda_d     = regs_q[ptr_q][7];
                            bit_cnt_d = 4'd1;
                        end else begin
                            state_d   = S_REG;
                            sda_d     = 1'b1;
                            bit_cnt_d = '0;
                        end
                    end
                end
                S_REG: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (reg_ok) begin
                            ptr_d   = shift_q[REG_AW-1:0];
                            state_d = S_ACK_REG;
                            sda_d   = 1'b0;
                        end else begin
                            state_d = S_IGNORE;
                            sda_d   = 1'b1;
                        end
                    end
                end
                S_ACK_REG, S_ACK_WR: begin
                    if (scl_fall) begin
                        state_d   = S_WR;
                        sda_d     = 1'b1;
                        bit_cnt_d = '0;
                    end
                end
                S_WR: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = shift_in;
                            ptr_d     = ptr_q + 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d = S_ACK_WR;
                        sda_d   = 1'b0;
                    end
                end
                S_RD: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = S_RD_ACK;
                            sda_d     = 1'b1;
                            bit_cnt_d = '0;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_d     = shift_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    // bit_cnt 0: waiting for master's ACK bit; 1: ACKed, next byte on the fall.
                    if (scl_rise && bit_cnt_q == 4'd0) begin
                        if (!sda_s2_q) begin
                            ptr_d     = ptr_q + 1'b1;
                            bit_cnt_d = 4'd1;
                        end else begin
                            state_d = S_IGNORE;
                            sda_d   = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        state_d   = S_RD;
                        shift_d   = regs_q[ptr_q];
                        sda_d     = regs_q[ptr_q][7];
                        bit_cnt_d = 4'd1;
                    end
                end
                S_IGNORE: begin
                    sda_d = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                    sda_d   = 1'b1;
                end
            endcase
        end
    end

    // Register file write port and the registered host read port (old data on same-cycle write).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            host_rdata_q <= '0;
        end else begin
            if (wr_en_d) begin
                regs_q[ptr_q] <= wr_data_d;
            end
            host_rdata_q <= regs_q[host_raddr];
        end
    end

    assign SDA_out    = sda_q;
    assign busy       = busy_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master plus a transaction-level register model.
// Latency: expectations are per transaction (ACK/data bits) and per cycle (host_rdata, wr_en).
// Backpressure: none; the bench master paces SCL at 8 clk per bit.
module tb_i2c_target_regfile;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       SDA_in;
    logic       SDA_out;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [3:0] host_raddr = 4'd0;
    logic [7:0] host_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] regs_m [16];
    logic [7:0] shadow [16];
    logic [3:0] ptr_m = 4'd0;
    wr_t        exp_q [$];
    logic [7:0] dbuf [8];
    logic [7:0] rbuf [4];
    logic       rst_last = 1'b1;
    logic [3:0] raddr_last = 4'd0;

    assign SDA_in = sda_m & SDA_out;

    i2c_target_regfile #(.DEV_ADDR(7'h50), .REG_AW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .SCL_in     (scl_m),
        .SDA_in     (SDA_in),
        .SDA_out    (SDA_out),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .host_raddr (host_raddr),
        .host_rdata (host_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    // Per-cycle checker: reset values, host read port against a shadow, wr_en against queued writes.
    always @(negedge clk) begin
        wr_t e;
        if (rst_last) begin
            chk("rst_sda_out", 32'(SDA_out), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_wr_en", 32'(wr_en), 32'd0);
            chk("rst_host_rdata", 32'(host_rdata), 32'd0);
            for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
            exp_q.delete();
        end else begin
            chk("host_rdata", 32'(host_rdata), 32'(shadow[raddr_last]));
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL wr_unexpected: got wr_en addr %0h data %0h, required no write", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(e.a));
                    chk("wr_data", 32'(wr_data), 32'(e.d));
                    shadow[e.a] = e.d;
                end
            end
        end
        rst_last   = rst;
        host_raddr = 4'($urandom_range(0, 15));
        raddr_last = host_raddr;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One SCL period: low 4 clk (data set after 1), high 4 clk; target drive sampled mid-high.
    task automatic mbit(input logic b, output logic t);
        scl_m = 1'b0;
        tick(1);
        sda_m = b;
        tick(3);
        scl_m = 1'b1;
        tick(2);
        t = SDA_out;
        tick(2);
    endtask

    task automatic start_c();
        scl_m = 1'b0;
        tick(1);
        sda_m = 1'b1;
        tick(3);
        scl_m = 1'b1;
        tick(2);
        sda_m = 1'b0;
        tick(2);
    endtask

    task automatic stop_c();
        scl_m = 1'b0;
        tick(1);
        sda_m = 1'b0;
        tick(3);
        scl_m = 1'b1;
        tick(2);
        sda_m = 1'b1;
        tick(4);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
        logic [7:0] drv;
        logic       t;
        drv = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            mbit(b[i], t);
            drv[i] = t;
        end
        chk({nm, "_released"}, 32'(drv), 32'hFF);
        mbit(1'b1, t);
        chk({nm, "_ack"}, 32'(t), exp_ack ? 32'd0 : 32'd1);
    endtask

    task automatic recv_byte(output logic [7:0] v, input logic mack);
        logic t;
        v = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            mbit(1'b1, t);
            v[i] = t;
        end
        mbit(mack, t);
        chk("rd_ack_slot_released", 32'(t), 32'd1);
    endtask

    // Write transfer: dev, reg, n data bytes from dbuf; model decides ACK/NACK and writes.
    task automatic write_txn(input logic [7:0] dev, input logic [7:0] rg, input int n);
        logic dev_ok;
        logic reg_ok;
        start_c();
        dev_ok = (dev[7:1] == 7'h50) && !dev[0];
        send_byte(dev, dev_ok, "dev");
        chk("busy_after_dev", 32'(busy), dev_ok ? 32'd1 : 32'd0);
        reg_ok = dev_ok && (rg < 8'd16);
        send_byte(rg, reg_ok, "reg");
        if (reg_ok) ptr_m = rg[3:0];
        for (int i = 0; i < n; i++) begin
            if (reg_ok) begin
                exp_q.push_back('{ptr_m, dbuf[i]});
                regs_m[ptr_m] = dbuf[i];
            end
            send_byte(dbuf[i], reg_ok, "wdata");
            if (reg_ok) ptr_m = ptr_m + 4'd1;
        end
        stop_c();
        tick(4);
        chk("busy_after_stop", 32'(busy), 32'd0);
    endtask

    // Combined read: dev W, reg, repeated START, dev R, n bytes (ACK all but last) into rbuf.
    task automatic read_txn(input logic [7:0] rg, input int n);
        logic [7:0] v;
        start_c();
        send_byte(8'hA0, 1'b1, "rd_devw");
        send_byte(rg, 1'b1, "rd_reg");
        ptr_m = rg[3:0];
        start_c();
        send_byte(8'hA1, 1'b1, "rd_devr");
        chk("busy_in_read", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            recv_byte(v, (i == n - 1));
            chk("rd_data", 32'(v), 32'(regs_m[ptr_m]));
            rbuf[i] = v;
            if (i != n - 1) ptr_m = ptr_m + 4'd1;
        end
        stop_c();
        tick(4);
        chk("busy_after_rd_stop", 32'(busy), 32'd0);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) regs_m[i] = 8'h00;
        ptr_m = 4'd0;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] dv;
        logic [7:0] rg;
        logic       t;
        int         n;

        model_clear();
        tick(4);
        chk("reset_sda_out", 32'(SDA_out), 32'd1);
        chk("reset_wr_addr", 32'(wr_addr), 32'd0);
        chk("reset_wr_data", 32'(wr_data), 32'd0);
        chk("reset_host_rdata", 32'(host_rdata), 32'd0);
        rst = 1'b0;
        tick(4);

        // Single write, then burst write wrapping 15 -> 0.
        dbuf[0] = 8'h5A;
        write_txn(8'hA0, 8'h03, 1);
        chk("lit_wr_addr_3", 32'(wr_addr), 32'd3);
        chk("lit_wr_data_5a", 32'(wr_data), 32'h5A);
        dbuf[0] = 8'h11;
        dbuf[1] = 8'h22;
        write_txn(8'hA0, 8'h0F, 2);
        chk("lit_wrap_addr_0", 32'(wr_addr), 32'd0);
        chk("lit_wrap_data_22", 32'(wr_data), 32'h22);

        // Combined and burst reads.
        read_txn(8'h03, 1);
        chk("lit_rd_reg3", 32'(rbuf[0]), 32'h5A);
        read_txn(8'h0F, 2);
        chk("lit_rd_reg15", 32'(rbuf[0]), 32'h11);
        chk("lit_rd_reg0", 32'(rbuf[1]), 32'h22);

        // Wrong device address and out-of-range register index are NACKed and write nothing.
        dbuf[0] = 8'h77;
        write_txn(8'hA2, 8'h03, 1);
        dbuf[0] = 8'h66;
        write_txn(8'hA0, 8'h20, 1);
        read_txn(8'h03, 1);
        chk("lit_rd_reg3_kept", 32'(rbuf[0]), 32'h5A);

        // Randomized traffic against the model.
        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 2) != 0) begin
                n  = $urandom_range(1, 4);
                dv = 8'hA0;
                if ($urandom_range(0, 5) == 0) dv = {7'($urandom_range(0, 127)), 1'b0};
                rg = 8'($urandom_range(0, 15));
                if ($urandom_range(0, 5) == 0) rg = 8'($urandom_range(16, 255));
                for (int i = 0; i < n; i++) dbuf[i] = 8'($urandom);
                write_txn(dv, rg, n);
            end else begin
                read_txn(8'($urandom_range(0, 15)), $urandom_range(1, 3));
            end
        end

        // Reset while the target is pulling SDA low for the device ACK.
        start_c();
        b = 8'hA0;
        for (int i = 7; i >= 0; i--) mbit(b[i], t);
        scl_m = 1'b0;
        tick(1);
        sda_m = 1'b1;
        tick(3);
        scl_m = 1'b1;
        tick(1);
        chk("ack_before_rst", 32'(SDA_out), 32'd0);
        rst = 1'b1;
        tick(1);
        chk("sda_released_after_rst", 32'(SDA_out), 32'd1);
        tick(3);
        rst = 1'b0;
        model_clear();
        tick(4);

        // Reset in the middle of a data byte: partial byte is dropped, registers cleared.
        dbuf[0] = 8'hAB;
        write_txn(8'hA0, 8'h03, 1);
        start_c();
        send_byte(8'hA0, 1'b1, "mid_dev");
        send_byte(8'h07, 1'b1, "mid_reg");
        b = 8'h3C;
        for (int i = 7; i >= 4; i--) mbit(b[i], t);
        rst = 1'b1;
        tick(1);
        chk("sda_after_mid_rst", 32'(SDA_out), 32'd1);
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(3);
        rst = 1'b0;
        model_clear();
        tick(4);
        read_txn(8'h03, 1);
        chk("lit_rd_reg3_cleared", 32'(rbuf[0]), 32'h00);
        dbuf[0] = 8'hC3;
        write_txn(8'hA0, 8'h05, 1);
        read_txn(8'h04, 2);
        chk("lit_rd_reg4_zero", 32'(rbuf[0]), 32'h00);
        chk("lit_rd_reg5_c3", 32'(rbuf[1]), 32'hC3);

        tick(6);
        chk("writes_pending", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
